// File: rtl/multicycle_div_unit.sv
// multicycle_div_unit: iterative restoring radix-2 divider for DIV/DIVU/REM/REMU and W variants.
// Operands are latched on the accept handshake. Divide-by-zero and signed overflow finish in
// one cycle. Other ops take N+2 cycles, where N is XLEN, or 32 for W ops.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, an op with |dividend| < |divisor|
// completes in one cycle with quot=0 and rem=dividend.
module multicycle_div_unit #(
    parameter int XLEN  = 64,
    parameter int HAS_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            div_sign,
    input  logic            div_w,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc, r_q, r_dvsr, r_quot, r_rem;
    logic            r_neg_q, r_neg_r, r_w, r_in_ready, r_out_valid;

    logic            w_w, w_accept, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_early, w_special, w_last;
    logic [XLEN-1:0] w_a, w_b, w_a_res, w_a_mag, w_b_mag, w_min, w_sp_quot, w_sp_rem;
    logic [XLEN:0]   w_shift, w_trial;
    logic [XLEN-1:0] w_q_fix, w_r_fix;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'(signed'(v));
    endfunction

    // Operand decode at accept: word masking, magnitudes and special-case detection
    always_comb begin
        w_w      = (HAS_W != 0) && div_w;
        w_a_res  = w_w ? sext32(rs1_data[31:0]) : rs1_data;
        w_a      = w_w ? (div_sign ? sext32(rs1_data[31:0]) : {{(XLEN-32){1'b0}}, rs1_data[31:0]}) : rs1_data;
        w_b      = w_w ? (div_sign ? sext32(rs2_data[31:0]) : {{(XLEN-32){1'b0}}, rs2_data[31:0]}) : rs2_data;
        w_a_neg  = div_sign & w_a[XLEN-1];
        w_b_neg  = div_sign & w_b[XLEN-1];
        w_a_mag  = w_a_neg ? -w_a : w_a;
        w_b_mag  = w_b_neg ? -w_b : w_b;
        w_min    = w_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        w_b_zero = (w_b == {XLEN{1'b0}});
        w_ovf    = div_sign && (w_a == w_min) && (w_b == {XLEN{1'b1}});
`ifdef DIV_EARLY_OUT_EN
        w_early  = !w_b_zero && (w_a_mag < w_b_mag);
`else
        w_early  = 1'b0;
`endif
        w_special = w_b_zero || w_ovf || w_early;
        w_accept  = (r_state == S_IDLE) && in_valid && !flush;
    end

    // One-cycle results for divide-by-zero, overflow and early-out
    always_comb begin
        w_sp_quot = {XLEN{1'b0}};
        w_sp_rem  = {XLEN{1'b0}};
        if (w_b_zero) begin
            w_sp_quot = {XLEN{1'b1}};
            w_sp_rem  = w_a_res;
        end else if (w_ovf) begin
            w_sp_quot = w_min;
            w_sp_rem  = {XLEN{1'b0}};
        end else begin
            w_sp_quot = {XLEN{1'b0}};
            w_sp_rem  = w_a_res;
        end
    end

    // Restoring step, iteration end detection and sign fix-up of the final magnitudes
    always_comb begin
        w_shift = {r_acc, r_q[XLEN-1]};
        w_trial = w_shift - {1'b0, r_dvsr};
        w_last  = (r_cnt == (r_w ? CW'(31) : CW'(XLEN-1)));
        w_q_fix = r_neg_q ? -r_q : r_q;
        w_r_fix = r_neg_r ? -r_acc : r_acc;
    end

    // Next-state logic; flush returns to IDLE from any state and blocks a new accept
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = in_valid ? (w_special ? S_DONE : S_CALC) : S_IDLE;
                S_CALC:  w_state_next = w_last ? S_FIX : S_CALC;
                S_FIX:   w_state_next = S_DONE;
                S_DONE:  w_state_next = out_ready ? S_IDLE : S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register and registered handshake flags derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, produce signed results in FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= {CW{1'b0}};
            r_acc   <= {XLEN{1'b0}};
            r_q     <= {XLEN{1'b0}};
            r_dvsr  <= {XLEN{1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_w     <= 1'b0;
            r_quot  <= {XLEN{1'b0}};
            r_rem   <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= {CW{1'b0}};
                        r_acc   <= {XLEN{1'b0}};
                        // W magnitudes are top-aligned so 32 steps consume exactly their bits
                        r_q     <= w_w ? (w_a_mag << (XLEN-32)) : w_a_mag;
                        r_dvsr  <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_w     <= w_w;
                        if (w_special) begin
                            r_quot <= w_sp_quot;
                            r_rem  <= w_sp_rem;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!w_trial[XLEN]) begin
                        r_acc <= w_trial[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_acc <= w_shift[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_quot <= r_w ? sext32(w_q_fix[31:0]) : w_q_fix;
                        r_rem  <= r_w ? sext32(w_r_fix[31:0]) : w_r_fix;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quot      = r_quot;
    assign rem       = r_rem;

endmodule

// File: tb/tb_multicycle_div_unit.sv
// Directed bench for multicycle_div_unit (XLEN=64, HAS_W=1) with a result scoreboard.
module tb_multicycle_div_unit;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, div_sign, div_w, out_valid, out_ready;
    logic [XLEN-1:0] rs1_data, rs2_data, quot, rem;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_div_unit #(.XLEN(XLEN), .HAS_W(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .div_sign(div_sign), .div_w(div_w),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        sx = {{32{v[31]}}, v};
    endfunction

    // Reference model: SV arithmetic plus the architectural special cases
    function automatic void model(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [31:0] q32, r32, ma32, mb32;
        logic [63:0] ma, mb;
        lat = w ? 34 : 66;
        if (w) begin
            if (b[31:0] == 32'd0) begin q = '1; r = sx(a[31:0]); lat = 1; return; end
            if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q = 64'hFFFF_FFFF_8000_0000; r = 64'd0; lat = 1; return;
            end
            if (s) begin
                q32 = $signed(a[31:0]) / $signed(b[31:0]);
                r32 = $signed(a[31:0]) % $signed(b[31:0]);
            end else begin
                q32 = a[31:0] / b[31:0];
                r32 = a[31:0] % b[31:0];
            end
            q = sx(q32); r = sx(r32);
            ma32 = (s && a[31]) ? (~a[31:0] + 32'd1) : a[31:0];
            mb32 = (s && b[31]) ? (~b[31:0] + 32'd1) : b[31:0];
`ifdef DIV_EARLY_OUT_EN
            if (ma32 < mb32) lat = 1;
`endif
        end else begin
            if (b == 64'd0) begin q = '1; r = a; lat = 1; return; end
            if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = 64'h8000_0000_0000_0000; r = 64'd0; lat = 1; return;
            end
            if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            ma = (s && a[63]) ? (~a + 64'd1) : a;
            mb = (s && b[63]) ? (~b + 64'd1) : b;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) lat = 1;
`endif
        end
    endfunction

    // Issue one op from IDLE, push expectation, wait for result, compare, optionally stall the consumer
    task automatic do_op(input string tag, input logic s, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                         input int elat, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        div_sign = s; div_w = w; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back('{eq, er, elat});
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_data = 64'hDEAD_BEEF_0BAD_F00D;
        rs2_data = 64'h0000_0000_0000_0001;
        div_sign = ~s;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " quot"}, quot, e.q);
        check({tag, " rem"}, rem, e.r);
        if (hold != 0) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
                check({tag, " hold quot"}, quot, e.q);
                check({tag, " hold rem"}, rem, e.r);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
        check({tag, " out_valid after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic model_op(input string tag, input logic s, input logic w, input logic [63:0] a,
                            input logic [63:0] b);
        logic [63:0] q, r;
        int          lat;
        model(s, w, a, b, q, r, lat);
        do_op(tag, s, w, a, b, q, r, lat, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [63:0] ra, rb;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; div_sign = 1'b0; div_w = 1'b0;
        rs1_data = 64'd0; rs2_data = 64'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset quot", quot, 64'd0);
        check("reset rem", rem, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("div -7/2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        do_op("divuw ffffffff/1", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34, 0);
        do_op("divu 100/0", 1'b0, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1, 0);
        do_op("divw ovf", 1'b1, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
        do_op("div ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'd0, 1, 0);
        do_op("divw by zero", 1'b1, 1'b1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1, 0);
        do_op("remw -7/3", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3,
              64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
`ifdef DIV_EARLY_OUT_EN
        do_op("divu 3/10", 1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 1, 0);
`else
        do_op("divu 3/10", 1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 66, 0);
`endif
        do_op("divu 1000/7 hold", 1'b0, 1'b0, 64'd1000, 64'd7, 64'd142, 64'd6, 66, 1);

        // Flush mid-calculation: no result may ever appear
        @(negedge clk);
        div_sign = 1'b0; div_w = 1'b0; rs1_data = 64'd1000; rs2_data = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);
        do_op("divu 9/2 after flush", 1'b0, 1'b0, 64'd9, 64'd2, 64'd4, 64'd1, 66, 0);

        // Flush together with in_valid in IDLE: the request is not taken
        @(negedge clk);
        rs1_data = 64'd50; rs2_data = 64'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush beats in_valid", 64'(in_ready), 64'd1);

        // Async reset in the middle of an op
        @(negedge clk);
        div_sign = 1'b0; div_w = 1'b0; rs1_data = 64'd77; rs2_data = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst quot", quot, 64'd0);
        check("async rst rem", rem, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Model-driven mixed ops
        model_op("div big", 1'b1, 1'b0, 64'h8000_0000_0000_0001, 64'd12345);
        model_op("remu big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0003);
        model_op("divw neg/neg", 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0000_FFFF_FFFD);
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {32'd0, $urandom} >> $urandom_range(0, 24);
            model_op("rand", 1'(i[0]), 1'(i[1]), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
